// File: rtl/skiroc2_sc_loader.sv
// Purpose : loads one 76-bit SKIROC2 slow-control frame (12-bit DAC code, 64-bit mask)
//           into the chip shift register on each Set_SC start pulse.
// Latency : SR_RSTB falls 1 cycle after Set_SC. The first SR_CK rise is 1+RST_CYC+HALF_PER cycles
//           after Set_SC. Sc_End rises 1+RST_CYC+FRAME_BITS*2*HALF_PER cycles after Set_SC.
// Backpr. : no queueing; Set_SC is accepted only while idle (Out_Busy=0) and is otherwise dropped.
//
// Ports:
//   Clk_10M, Rst_N          : clock and synchronous active-low reset
//   In_Set_SC               : start pulse, sampled only in IDLE
//   In_DAC_Code/Mask_Code   : frame contents, latched at start
//   In_Sr_Out               : chip SR_OUT, used only with SC_READBACK_EN
//   Out_Sr_Rstb/Ck/In       : chip shift register reset, clock and serial data (MSB first)
//   Out_Busy, Out_Sc_End    : busy flag, and a load-complete pulse that is END_CYC cycles wide
//   Out_Sc_Err              : readback mismatch flag; sticky until the next accepted start
//
// Optional feature macro: SC_READBACK_EN. Defining it adds a second pass that replays the
// frame and checks the chip's SR_OUT against the first pass. Without it Out_Sc_Err is tied to 0.

module skiroc2_sc_loader #(
   parameter int HALF_PER = 2,
   parameter int RST_CYC  = 4,
   parameter int END_CYC  = 2
) (
   input  logic        Clk_10M,
   input  logic        Rst_N,
   input  logic        In_Set_SC,
   input  logic [63:0] In_Mask_Code,
   input  logic [11:0] In_DAC_Code,
   input  logic        In_Sr_Out,
   output logic        Out_Sr_Rstb,
   output logic        Out_Sr_Ck,
   output logic        Out_Sr_In,
   output logic        Out_Busy,
   output logic        Out_Sc_End,
   output logic        Out_Sc_Err
);

   localparam int         FRAME_BITS = 76;
   localparam logic [6:0] FRAME_LEN7 = 7'(FRAME_BITS);
   localparam logic [3:0] HALF_LAST  = 4'(HALF_PER - 1);
   localparam logic [3:0] RST_LAST   = 4'(RST_CYC - 1);
   localparam logic [3:0] END_LAST   = 4'(END_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_DONE
   } state_t;

   state_t                state;
   logic [3:0]            ph_cnt;    // cycles spent in the current phase
   logic [6:0]            bit_cnt;   // bits fully clocked out in the current pass
   logic [6:0]            bit_nxt;
   logic [FRAME_BITS-1:0] frame;     // working shift copy; MSB is the bit on the wire

`ifdef SC_READBACK_EN
   logic [FRAME_BITS-1:0] frame_copy; // untouched copy that is replayed in pass 2
   logic                  pass2;
`else
   logic                  unused_sr_out;
   assign unused_sr_out = In_Sr_Out;
   assign Out_Sc_Err    = 1'b0;
`endif

   assign bit_nxt = bit_cnt + 7'd1;

   always_ff @(posedge Clk_10M) begin
      if (!Rst_N) begin
         state       <= S_IDLE;
         ph_cnt      <= '0;
         bit_cnt     <= '0;
         frame       <= '0;
         Out_Sr_Rstb <= 1'b1;
         Out_Sr_Ck   <= 1'b0;
         Out_Sr_In   <= 1'b0;
         Out_Busy    <= 1'b0;
         Out_Sc_End  <= 1'b0;
`ifdef SC_READBACK_EN
         frame_copy  <= '0;
         pass2       <= 1'b0;
         Out_Sc_Err  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (In_Set_SC) begin
                  frame       <= {In_DAC_Code, In_Mask_Code};
                  ph_cnt      <= '0;
                  bit_cnt     <= '0;
                  Out_Sr_Rstb <= 1'b0;
                  Out_Busy    <= 1'b1;
                  state       <= S_RST;
`ifdef SC_READBACK_EN
                  frame_copy  <= {In_DAC_Code, In_Mask_Code};
                  pass2       <= 1'b0;
                  Out_Sc_Err  <= 1'b0;
`endif
               end
            end

            S_RST: begin
               if (ph_cnt == RST_LAST) begin
                  ph_cnt      <= '0;
                  Out_Sr_Rstb <= 1'b1;
                  Out_Sr_Ck   <= 1'b0;
                  Out_Sr_In   <= frame[FRAME_BITS-1];
                  state       <= S_SHIFT_LO;
               end else begin
                  ph_cnt <= ph_cnt + 4'd1;
               end
            end

            S_SHIFT_LO: begin
`ifdef SC_READBACK_EN
               // In pass 2, SR_OUT presents the pass-1 bit at the same index just
               // before the rising edge that pushes it out.
               if (pass2 && (ph_cnt == HALF_LAST) && (In_Sr_Out != frame[FRAME_BITS-1]))
                  Out_Sc_Err <= 1'b1;
`endif
               if (ph_cnt == HALF_LAST) begin
                  ph_cnt    <= '0;
                  Out_Sr_Ck <= 1'b1;
                  state     <= S_SHIFT_HI;
               end else begin
                  ph_cnt <= ph_cnt + 4'd1;
               end
            end

            S_SHIFT_HI: begin
               if (ph_cnt == HALF_LAST) begin
                  ph_cnt    <= '0;
                  Out_Sr_Ck <= 1'b0;
                  if (bit_nxt != FRAME_LEN7) begin
                     // Present the next bit together with the falling clock so that it
                     // is stable for a full low phase before the next rise.
                     frame     <= {frame[FRAME_BITS-2:0], 1'b0};
                     bit_cnt   <= bit_nxt;
                     Out_Sr_In <= frame[FRAME_BITS-2];
                     state     <= S_SHIFT_LO;
                  end
`ifdef SC_READBACK_EN
                  else if (!pass2) begin
                     // Replay without an SR reset. Rewriting the same data leaves the chip unchanged.
                     pass2     <= 1'b1;
                     frame     <= frame_copy;
                     bit_cnt   <= '0;
                     Out_Sr_In <= frame_copy[FRAME_BITS-1];
                     state     <= S_SHIFT_LO;
                  end
`endif
                  else begin
                     frame      <= '0;
                     bit_cnt    <= '0;
                     Out_Sr_In  <= 1'b0;
                     Out_Sc_End <= 1'b1;
                     state      <= S_DONE;
                  end
               end else begin
                  ph_cnt <= ph_cnt + 4'd1;
               end
            end

            S_DONE: begin
               if (ph_cnt == END_LAST) begin
                  ph_cnt     <= '0;
                  Out_Sc_End <= 1'b0;
                  Out_Busy   <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  ph_cnt <= ph_cnt + 4'd1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skiroc2_sc_loader.sv
// Testbench for skiroc2_sc_loader.
// It runs table vectors, random frames, and hand-written corner sequences (mid-frame start,
// start in the last DONE cycle, mid-frame reset, back-to-back loads, readback fault).
// Expected values come from the frame rule {DAC, Mask} sent MSB first and from the timing formulas.

module tb_skiroc2_sc_loader;

   localparam int HALF_PER   = 2;
   localparam int RST_CYC    = 4;
   localparam int END_CYC    = 2;
   localparam int FRAME_BITS = 76;
`ifdef SC_READBACK_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif
   localparam int FIRST_RISE_DLY = 1 + RST_CYC + HALF_PER;
   localparam int END_DLY        = 1 + RST_CYC + PASSES * FRAME_BITS * 2 * HALF_PER;

   logic        Clk_10M = 1'b0;
   logic        Rst_N;
   logic        In_Set_SC;
   logic [63:0] In_Mask_Code;
   logic [11:0] In_DAC_Code;
   logic        In_Sr_Out;
   logic        Out_Sr_Rstb;
   logic        Out_Sr_Ck;
   logic        Out_Sr_In;
   logic        Out_Busy;
   logic        Out_Sc_End;
   logic        Out_Sc_Err;

   skiroc2_sc_loader #(
      .HALF_PER (HALF_PER),
      .RST_CYC  (RST_CYC),
      .END_CYC  (END_CYC)
   ) dut (
      .Clk_10M      (Clk_10M),
      .Rst_N        (Rst_N),
      .In_Set_SC    (In_Set_SC),
      .In_Mask_Code (In_Mask_Code),
      .In_DAC_Code  (In_DAC_Code),
      .In_Sr_Out    (In_Sr_Out),
      .Out_Sr_Rstb  (Out_Sr_Rstb),
      .Out_Sr_Ck    (Out_Sr_Ck),
      .Out_Sr_In    (Out_Sr_In),
      .Out_Busy     (Out_Busy),
      .Out_Sc_End   (Out_Sc_End),
      .Out_Sc_Err   (Out_Sc_Err)
   );

   always #5 Clk_10M = ~Clk_10M;

   int pcnt = 0;
   always @(posedge Clk_10M) pcnt <= pcnt + 1;

   // Chip-side 76-deep shift register. Optionally inverts the bit read back for pass-2 bit 10.
   logic [75:0] chip_sr    = '0;
   int          chip_rises = 0;
   bit          flip_mode  = 1'b0;
   always @(posedge Out_Sr_Ck or negedge Out_Sr_Rstb) begin
      if (!Out_Sr_Rstb) begin
         chip_sr    <= '0;
         chip_rises <= 0;
      end else begin
         chip_sr    <= {chip_sr[74:0], Out_Sr_In};
         chip_rises <= chip_rises + 1;
      end
   end
   assign In_Sr_Out = chip_sr[75] ^ (flip_mode && (chip_rises == FRAME_BITS + 10));

   // Monitor on the falling edge: captured bits, edge times, cumulative phase counts.
   logic cap_q[$];
   int   rise_t[$];
   int   end_t[$];
   logic err_q[$];
   int   rstb_low = 0;
   int   end_high = 0;
   logic prev_ck  = 1'b0;
   logic prev_end = 1'b0;
   always @(negedge Clk_10M) begin
      if (Out_Sr_Ck === 1'b1 && prev_ck !== 1'b1) begin
         cap_q.push_back(Out_Sr_In);
         rise_t.push_back(pcnt);
      end
      if (Out_Sc_End === 1'b1 && prev_end !== 1'b1) begin
         end_t.push_back(pcnt);
         err_q.push_back(Out_Sc_Err);
      end
      if (Out_Sr_Rstb === 1'b0) rstb_low <= rstb_low + 1;
      if (Out_Sc_End === 1'b1)  end_high <= end_high + 1;
      prev_ck  <= Out_Sr_Ck;
      prev_end <= Out_Sc_End;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_10M);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (Out_Busy !== 1'b0 && n < 2000) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, Out_Busy, 0);
   endtask

   // One complete load, checked against the frame rule and the timing formulas.
   task automatic do_load(input string tag, input logic [11:0] dac, input logic [63:0] mask,
                          input logic [75:0] exp_frame, input bit disturb, input bit exp_err);
      int base_cap, base_end, base_rstb, base_endhi, p0, n;
      logic [75:0] got1;
      logic [75:0] got2;
      wait_idle(tag);
      base_cap   = cap_q.size();
      base_end   = end_t.size();
      base_rstb  = rstb_low;
      base_endhi = end_high;
      In_DAC_Code  = dac;
      In_Mask_Code = mask;
      In_Set_SC    = 1'b1;
      p0 = pcnt;
      tick();
      In_Set_SC = 1'b0;
      chk({tag, "_busy"}, Out_Busy, 1);
      chk({tag, "_rstb_fall"}, Out_Sr_Rstb, 0);
      chk({tag, "_err_clr"}, Out_Sc_Err, 0);
      n = 0;
      while (end_t.size() == base_end && n < END_DLY + 100) begin
         if (disturb && n == 49) begin
            In_Set_SC    = 1'b1;
            In_DAC_Code  = ~dac;
            In_Mask_Code = ~mask;
         end
         if (disturb && n == 50) In_Set_SC = 1'b0;
         tick();
         n++;
      end
      n = 0;
      while (Out_Busy !== 1'b0 && n < 100) begin
         tick();
         n++;
      end
      if (disturb) repeat (20) tick();
      chk({tag, "_n_end"}, end_t.size() - base_end, 1);
      chk({tag, "_n_rise"}, cap_q.size() - base_cap, PASSES * FRAME_BITS);
      got1 = '0;
      got2 = '0;
      for (int i = 0; i < FRAME_BITS; i++) begin
         if (base_cap + i < cap_q.size()) got1[FRAME_BITS-1-i] = cap_q[base_cap+i];
         if (base_cap + FRAME_BITS + i < cap_q.size()) got2[FRAME_BITS-1-i] = cap_q[base_cap+FRAME_BITS+i];
      end
      chk({tag, "_frame"}, got1, exp_frame);
`ifdef SC_READBACK_EN
      chk({tag, "_frame_pass2"}, got2, exp_frame);
`endif
      if (cap_q.size() > base_cap)
         chk({tag, "_first_rise"}, rise_t[base_cap] - p0, FIRST_RISE_DLY);
      if (end_t.size() > base_end) begin
         chk({tag, "_end_dly"}, end_t[base_end] - p0, END_DLY);
         chk({tag, "_err_at_end"}, err_q[base_end], exp_err);
      end
      chk({tag, "_rstb_cyc"}, rstb_low - base_rstb, RST_CYC);
      chk({tag, "_end_cyc"}, end_high - base_endhi, END_CYC);
      chk({tag, "_busy_after"}, Out_Busy, 0);
   endtask

   typedef struct {
      logic [11:0] dac;
      logic [63:0] mask;
      logic [75:0] exp_frame;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int          n, base_cap, base_end, base_rstb;
      logic [11:0] rdac;
      logic [63:0] rmask;

      vecs[0] = '{12'hABC, 64'h7FFF_FFFF_FFFF_FFFF, 76'hABC_7FFF_FFFF_FFFF_FFFF};
      vecs[1] = '{12'h000, 64'h0000_0000_0000_0000, 76'h000_0000_0000_0000_0000};
      vecs[2] = '{12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 76'hFFF_FFFF_FFFF_FFFF_FFFF};
      vecs[3] = '{12'h123, 64'h8000_0000_0000_0001, 76'h123_8000_0000_0000_0001};

      Rst_N        = 1'b0;
      In_Set_SC    = 1'b0;
      In_DAC_Code  = '0;
      In_Mask_Code = '0;
      repeat (3) tick();
      chk("rst_rstb", Out_Sr_Rstb, 1);
      chk("rst_ck",   Out_Sr_Ck,   0);
      chk("rst_in",   Out_Sr_In,   0);
      chk("rst_busy", Out_Busy,    0);
      chk("rst_end",  Out_Sc_End,  0);
      chk("rst_err",  Out_Sc_Err,  0);
      Rst_N = 1'b1;
      tick();

      for (int i = 0; i < 4; i++)
         do_load($sformatf("vec%0d", i), vecs[i].dac, vecs[i].mask, vecs[i].exp_frame, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         rdac  = 12'($urandom);
         rmask = {$urandom, $urandom};
         do_load($sformatf("rnd%0d", i), rdac, rmask, {rdac, rmask}, 1'b0, 1'b0);
      end

      // A second start and new inputs mid-frame must not disturb the frame in flight.
      do_load("midframe", 12'h5A5, 64'hDEAD_BEEF_0123_4567, 76'h5A5_DEAD_BEEF_0123_4567, 1'b1, 1'b0);

      // A start in the last DONE cycle is dropped.
      wait_idle("lastdone");
      base_rstb    = rstb_low;
      In_DAC_Code  = 12'h321;
      In_Mask_Code = 64'h0F0F_0F0F_0F0F_0F0F;
      In_Set_SC    = 1'b1;
      tick();
      In_Set_SC = 1'b0;
      n = 0;
      while (Out_Sc_End !== 1'b1 && n < END_DLY + 50) begin
         tick();
         n++;
      end
      chk("lastdone_end_seen", Out_Sc_End, 1);
      repeat (END_CYC - 1) tick();
      In_Set_SC = 1'b1;
      tick();
      In_Set_SC = 1'b0;
      chk("lastdone_busy", Out_Busy, 0);
      repeat (10) tick();
      chk("lastdone_busy_later", Out_Busy, 0);
      chk("lastdone_rstb", rstb_low - base_rstb, RST_CYC);

      // Reset pulse at bit 30 aborts the frame without Sc_End.
      wait_idle("rst30");
      base_cap     = cap_q.size();
      base_end     = end_t.size();
      In_DAC_Code  = 12'hC3C;
      In_Mask_Code = 64'h1111_2222_3333_4444;
      In_Set_SC    = 1'b1;
      tick();
      In_Set_SC = 1'b0;
      n = 0;
      while (cap_q.size() - base_cap < 30 && n < 500) begin
         tick();
         n++;
      end
      chk("rst30_reached", cap_q.size() - base_cap, 30);
      Rst_N = 1'b0;
      tick();
      Rst_N = 1'b1;
      chk("rst30_ck",   Out_Sr_Ck,   0);
      chk("rst30_rstb", Out_Sr_Rstb, 1);
      chk("rst30_busy", Out_Busy,    0);
      chk("rst30_end",  Out_Sc_End,  0);
      repeat (400) tick();
      chk("rst30_no_end", end_t.size() - base_end, 0);
      do_load("after_rst", 12'h9E7, 64'hA5A5_5A5A_F00F_0FF0, 76'h9E7_A5A5_5A5A_F00F_0FF0, 1'b0, 1'b0);

      // Back-to-back loads. Each start is issued as soon as the previous Sc_End has fallen.
      do_load("b2b0", 12'h000, 64'h0123_4567_89AB_CDEF, 76'h000_0123_4567_89AB_CDEF, 1'b0, 1'b0);
      do_load("b2b1", 12'hFFF, 64'h0123_4567_89AB_CDEF, 76'hFFF_0123_4567_89AB_CDEF, 1'b0, 1'b0);

`ifdef SC_READBACK_EN
      // The chip model corrupts one readback bit. The error flag is sticky until the next start.
      flip_mode = 1'b1;
      do_load("rb_bad", 12'h456, 64'hCAFE_F00D_1234_5678, 76'h456_CAFE_F00D_1234_5678, 1'b0, 1'b1);
      flip_mode = 1'b0;
      repeat (5) tick();
      chk("rb_err_sticky", Out_Sc_Err, 1);
      do_load("rb_clear", 12'h456, 64'hCAFE_F00D_1234_5678, 76'h456_CAFE_F00D_1234_5678, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
